// File: rtl/cla5_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cla5_pkg
//  Purpose  : Shared constants and helpers for the cla5 adder and its
//             result checker.
//             - CLA_WIDTH    : operand width of the cla5 adder
//             - CLA_LATENCY  : adder input-to-output latency in clk cycles
//             - cla_result_t : {carry_out, sum} result type
//             - golden_sum   : reference sum computed without truncation
//  Revision : 1.0  initial release
// ============================================================================
package cla5_pkg;

   localparam int CLA_WIDTH   = 5;
   localparam int CLA_LATENCY = 3;

   typedef logic [CLA_WIDTH:0] cla_result_t;

   // The operands are widened before the add so the carry-out lands in the MSB.
   function automatic cla_result_t golden_sum(
      input logic [CLA_WIDTH-1:0] a,
      input logic [CLA_WIDTH-1:0] b,
      input logic                 cin
   );
      return cla_result_t'({1'b0, a}) + cla_result_t'({1'b0, b}) + cla_result_t'(cin);
   endfunction

endpackage : cla5_pkg
`default_nettype wire

// File: rtl/chk_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : chk_delay_line
//  Purpose  : DEPTH-stage shift register carrying a valid bit and a W-bit
//             payload. The output stage holds an entry DEPTH-1 edges after it
//             was loaded, so a consumer that samples it on the next edge sees
//             the entry exactly DEPTH edges after ingress.
//  Ports    : clk       in   rising-edge clock
//             rst       in   asynchronous active-high reset
//             flush     in   synchronous flush of entries already in flight
//             in_valid  in   entry valid at ingress
//             in_data   in   W-bit payload at ingress
//             out_valid out  valid of the oldest stage
//             out_data  out  payload of the oldest stage
//  Revision : 1.0  initial release
// ============================================================================
module chk_delay_line #(
   parameter int W     = 6,
   parameter int DEPTH = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic [DEPTH-1:0] valid_q;
   logic [W-1:0]     data_q [DEPTH];

   // Flush clears only the older stages: an entry presented on the flush
   // edge itself is still captured into stage 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q[0] <= in_valid;
         data_q[0]  <= in_data;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= flush ? 1'b0 : valid_q[i-1];
            data_q[i]  <= data_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];

endmodule : chk_delay_line
`default_nettype wire

// File: rtl/cla5_result_checker.sv
`default_nettype none
// ============================================================================
//  Module   : cla5_result_checker
//  Purpose  : Consumer end of the cla5 pipelined adder. Every operand set
//             driven into the adder gets a golden sum that is delayed by the
//             adder latency and compared with the adder's {Cout_out,S_out}.
//             Pass/fail counters saturate; err_sticky latches the first fail.
//  Config   : CHK_CAPTURE_EN - when defined, adds fail_a/fail_b/fail_cin/
//             fail_got, which hold operands and observed result of the first
//             failing compare. Operands then travel down the delay line too.
//  Ports    : clk        in   rising-edge clock
//             rst        in   asynchronous active-high reset
//             clr        in   synchronous clear of counters, flag, in-flight
//             in_valid   in   operands presented to the adder this cycle
//             A_in/B_in  in   WIDTH-bit operands
//             Cin_in     in   carry in
//             S_out      in   WIDTH-bit adder sum
//             Cout_out   in   adder carry out
//             chk_valid  out  one-cycle pulse per completed compare
//             mismatch   out  compare failed (qualified by chk_valid)
//             pass_cnt   out  saturating count of passing compares
//             fail_cnt   out  saturating count of failing compares
//             err_sticky out  set on first failure, held until rst/clr
//  Revision : 1.0  initial release
// ============================================================================
module cla5_result_checker
   import cla5_pkg::*;
#(
   parameter int WIDTH   = CLA_WIDTH,
   parameter int LATENCY = CLA_LATENCY,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   input  logic             Cin_in,
   input  logic [WIDTH-1:0] S_out,
   input  logic             Cout_out,
   output logic             chk_valid,
   output logic             mismatch,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             err_sticky
`ifdef CHK_CAPTURE_EN
   ,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic             fail_cin,
   output logic [WIDTH:0]   fail_got
`endif
);

   localparam int RES_W = WIDTH + 1;

   // ------------------------------------------------------------------------
   // Golden sum at ingress
   // ------------------------------------------------------------------------
   logic [RES_W-1:0] golden;

   generate
      if (WIDTH == CLA_WIDTH) begin : g_pkg_golden
         assign golden = golden_sum(A_in, B_in, Cin_in);
      end else begin : g_generic_golden
         assign golden = {1'b0, A_in} + {1'b0, B_in} + RES_W'(Cin_in);
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Delay line payload: golden only, or operands + golden with capture
   // ------------------------------------------------------------------------
`ifdef CHK_CAPTURE_EN
   localparam int PAY_W = 2 * WIDTH + 1 + RES_W;
   logic [PAY_W-1:0] pay_in;
   assign pay_in = {A_in, B_in, Cin_in, golden};
`else
   localparam int PAY_W = RES_W;
   logic [PAY_W-1:0] pay_in;
   assign pay_in = golden;
`endif

   logic             d_valid;
   logic [PAY_W-1:0] d_pay;

   chk_delay_line #(
      .W     (PAY_W),
      .DEPTH (LATENCY)
   ) u_delay (
      .clk       (clk),
      .rst       (rst),
      .flush     (clr),
      .in_valid  (in_valid),
      .in_data   (pay_in),
      .out_valid (d_valid),
      .out_data  (d_pay)
   );

   // ------------------------------------------------------------------------
   // Compare against the adder output
   // ------------------------------------------------------------------------
   logic [RES_W-1:0] d_golden;
   logic [RES_W-1:0] observed;
   logic             miss;

   assign d_golden = d_pay[RES_W-1:0];
   assign observed = {Cout_out, S_out};
   assign miss     = (observed != d_golden);

   // clr takes priority over a compare landing on the same edge, so the
   // discarded compare leaves no trace in the counters or the flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_valid  <= 1'b0;
         mismatch   <= 1'b0;
         pass_cnt   <= '0;
         fail_cnt   <= '0;
         err_sticky <= 1'b0;
      end else if (clr) begin
         chk_valid  <= 1'b0;
         mismatch   <= 1'b0;
         pass_cnt   <= '0;
         fail_cnt   <= '0;
         err_sticky <= 1'b0;
      end else begin
         chk_valid <= d_valid;
         mismatch  <= d_valid & miss;
         if (d_valid) begin
            if (miss) begin
               if (fail_cnt != '1) begin
                  fail_cnt <= fail_cnt + CNT_W'(1);
               end
               err_sticky <= 1'b1;
            end else begin
               if (pass_cnt != '1) begin
                  pass_cnt <= pass_cnt + CNT_W'(1);
               end
            end
         end
      end
   end

`ifdef CHK_CAPTURE_EN
   // ------------------------------------------------------------------------
   // First-failure capture: loaded only while err_sticky is still clear
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_a   <= '0;
         fail_b   <= '0;
         fail_cin <= 1'b0;
         fail_got <= '0;
      end else if (clr) begin
         fail_a   <= '0;
         fail_b   <= '0;
         fail_cin <= 1'b0;
         fail_got <= '0;
      end else if (d_valid && miss && !err_sticky) begin
         fail_a   <= d_pay[PAY_W-1 -: WIDTH];
         fail_b   <= d_pay[PAY_W-1-WIDTH -: WIDTH];
         fail_cin <= d_pay[RES_W];
         fail_got <= observed;
      end
   end
`endif

endmodule : cla5_result_checker
`default_nettype wire

// File: tb/tb_cla5_result_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla5_result_checker
//  Purpose  : Self-checking bench for cla5_result_checker. The bench plays
//             the role of a 3-cycle adder (with optional corrupted results)
//             and keeps a transaction-level model: a history of issued
//             operand sets, which of them are still alive, and plain integer
//             pass/fail tallies. A second instance with CNT_W=2 shares the
//             stimulus to exercise counter saturation.
//  Config   : CHK_CAPTURE_EN - also checks the first-failure capture ports.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cla5_result_checker;

   localparam int LAT  = 3;
   localparam int HMAX = 4096;

   logic       clk = 1'b0;
   logic       rst, clr, in_valid, Cin_in, Cout_out;
   logic [4:0] A_in, B_in, S_out;

   logic        chk_valid, mismatch, err_sticky;
   logic [15:0] pass_cnt, fail_cnt;
   logic        s_chk_valid, s_mismatch, s_err_sticky;
   logic [1:0]  s_pass_cnt, s_fail_cnt;
`ifdef CHK_CAPTURE_EN
   logic [4:0] fail_a, fail_b, s_fail_a, s_fail_b;
   logic       fail_cin, s_fail_cin;
   logic [5:0] fail_got, s_fail_got;
`endif

   always #5 clk = ~clk;

   cla5_result_checker #(.WIDTH(5), .LATENCY(LAT), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
      .A_in(A_in), .B_in(B_in), .Cin_in(Cin_in), .S_out(S_out), .Cout_out(Cout_out),
      .chk_valid(chk_valid), .mismatch(mismatch), .pass_cnt(pass_cnt),
      .fail_cnt(fail_cnt), .err_sticky(err_sticky)
`ifdef CHK_CAPTURE_EN
      , .fail_a(fail_a), .fail_b(fail_b), .fail_cin(fail_cin), .fail_got(fail_got)
`endif
   );

   cla5_result_checker #(.WIDTH(5), .LATENCY(LAT), .CNT_W(2)) dut_small (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
      .A_in(A_in), .B_in(B_in), .Cin_in(Cin_in), .S_out(S_out), .Cout_out(Cout_out),
      .chk_valid(s_chk_valid), .mismatch(s_mismatch), .pass_cnt(s_pass_cnt),
      .fail_cnt(s_fail_cnt), .err_sticky(s_err_sticky)
`ifdef CHK_CAPTURE_EN
      , .fail_a(s_fail_a), .fail_b(s_fail_b), .fail_cin(s_fail_cin), .fail_got(s_fail_got)
`endif
   );

   // ---------------- reference model state ----------------
   bit h_v     [HMAX];   // operand set issued at edge n
   bit h_bad   [HMAX];   // adder result for it is corrupted
   bit h_alive [HMAX];   // not yet discarded by clr/rst
   int h_a [HMAX], h_b [HMAX], h_c [HMAX];
   int n = 0;            // index of the next active edge
   int m_pass = 0, m_fail = 0;
   bit m_sticky = 0;
   int cap_a = 0, cap_b = 0, cap_c = 0, cap_got = 0;

   int tests = 0, fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat3(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   task automatic check_state(input bit e_chk, input bit e_mm);
      check("chk_valid", chk_valid, e_chk);
      check("mismatch", mismatch, e_mm);
      check("pass_cnt", pass_cnt, m_pass);
      check("fail_cnt", fail_cnt, m_fail);
      check("err_sticky", err_sticky, m_sticky);
      check("small_chk_valid", s_chk_valid, e_chk);
      check("small_pass_cnt", s_pass_cnt, sat3(m_pass));
      check("small_fail_cnt", s_fail_cnt, sat3(m_fail));
`ifdef CHK_CAPTURE_EN
      check("fail_a", fail_a, cap_a);
      check("fail_b", fail_b, cap_b);
      check("fail_cin", fail_cin, cap_c);
      check("fail_got", fail_got, cap_got);
`endif
   endtask

   // One active edge. Called at a negedge, returns at the following negedge.
   task automatic step(input bit v, input int a, input int b, input int cin,
                       input bit c, input bit bad);
      int         k;
      int         sum;
      logic [5:0] res;
      bit         e_chk, e_mm;
      in_valid = v; A_in = a[4:0]; B_in = b[4:0]; Cin_in = cin[0]; clr = c;
      h_v[n] = v; h_bad[n] = bad; h_alive[n] = 1'b1;
      h_a[n] = a; h_b[n] = b; h_c[n] = cin;
      // Adder model: result of the set issued LAT edges ago is on its outputs now.
      k = n - LAT;
      if (k >= 0 && h_v[k]) begin
         sum = h_a[k] + h_b[k] + h_c[k];
         res = 6'(sum) ^ {5'b0, h_bad[k]};
      end else begin
         res = 6'($urandom);
      end
      {Cout_out, S_out} = res;
      @(posedge clk);
      #1;
      e_chk = 0; e_mm = 0;
      if (c) begin
         m_pass = 0; m_fail = 0; m_sticky = 0;
         cap_a = 0; cap_b = 0; cap_c = 0; cap_got = 0;
         for (int j = 0; j < n; j++) h_alive[j] = 1'b0;
      end else if (k >= 0 && h_v[k] && h_alive[k]) begin
         e_chk = 1; e_mm = h_bad[k];
         if (e_mm) begin
            if (!m_sticky) begin
               cap_a = h_a[k]; cap_b = h_b[k]; cap_c = h_c[k]; cap_got = int'(res);
            end
            m_fail++; m_sticky = 1;
         end else begin
            m_pass++;
         end
      end
      check_state(e_chk, e_mm);
      n++;
      @(negedge clk);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++)
         step(0, $urandom_range(31), $urandom_range(31), $urandom_range(1), 0, 0);
   endtask

   // Asynchronous reset asserted mid-cycle; held across one edge.
   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; clr = 1'b0;
      #1;
      m_pass = 0; m_fail = 0; m_sticky = 0;
      cap_a = 0; cap_b = 0; cap_c = 0; cap_got = 0;
      for (int j = 0; j < n; j++) h_alive[j] = 1'b0;
      check_state(0, 0);
      @(posedge clk);
      h_v[n] = 1'b0; h_alive[n] = 1'b0;
      n++;
      #1;
      check_state(0, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 0; clr = 0; in_valid = 0; A_in = 0; B_in = 0; Cin_in = 0;
      S_out = 0; Cout_out = 0;
      @(negedge clk);
      do_reset();

      // 00011 + 00101 -> 0_01000
      step(1, 3, 5, 0, 0, 0);
      idle(2);
      check("pre_first_pulse", chk_valid, 0);
      idle(1);
      check("first_pulse", chk_valid, 1);
      check("first_pass_cnt", pass_cnt, 1);
      idle(1);

      // 11111 + 00111 -> 1_00110 (carry-out path)
      step(1, 31, 7, 0, 0, 0);
      idle(4);

      // back-to-back: 0_11000 then 1_11001
      step(1, 10, 14, 0, 0, 0);
      step(1, 28, 28, 1, 0, 0);
      idle(4);
      check("b2b_pass_cnt", pass_cnt, 4);

      // corrupted result then a good one
      step(1, 9, 4, 1, 0, 1);
      step(1, 2, 2, 0, 0, 0);
      idle(4);
      check("fault_fail_cnt", fail_cnt, 1);
      check("fault_sticky", err_sticky, 1);

      // saturation of the 2-bit instance
      for (int i = 0; i < 5; i++) step(1, i, 2 * i, i & 1, 0, 0);
      idle(4);
      check("small_saturated", s_pass_cnt, 3);

      // reset with two entries in flight
      step(1, 1, 1, 0, 0, 0);
      step(1, 4, 4, 1, 0, 0);
      do_reset();
      idle(5);

      // clr coincident with a compare, then clr with a new entry
      step(1, 6, 7, 0, 0, 0);
      idle(1);
      step(1, 3, 3, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(1, 12, 13, 1, 1, 0);
      idle(4);
      check("clr_new_entry_pass", pass_cnt, 1);

      // two distinct failures: capture keeps the first
      step(1, 5, 6, 1, 0, 1);
      idle(1);
      step(1, 17, 3, 0, 0, 1);
      idle(4);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(3) != 0, $urandom_range(31), $urandom_range(31),
              $urandom_range(1), $urandom_range(40) == 0, $urandom_range(9) == 0);
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_cla5_result_checker
`default_nettype wire
